// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch: LC-3 instruction-fetch / next-PC unit.
//
// Holds the program counter and drives it as the instruction-memory read
// address. On each fetch_start strobe the next PC is derived from the opcode
// of the instruction just executed: sequential, conditional branch, register
// jump (JMP/RET/JSR/JSRR) or HALT. Once halted, only reset resumes fetching.
//
// Ports:
//   clk         in   system clock, rising-edge active
//   rst_n       in   synchronous reset, active-high (1 = reset)
//   fetch_start in   one-cycle strobe: load next PC on this edge
//   opCode_in   in   [3:0]  opcode of the instruction just executed
//   offset_in   in   [8:0]  PCoffset9 (two's complement)
//   reg_in      in   [15:0] precomputed register target for JMP/JSR family
//   br_nzp      in   [2:0]  BR condition mask {n,z,p}
//   result_nzp  in   [2:0]  current condition codes {n,z,p}
//   addr_out    out  [15:0] instruction-memory address (== pc)
//   wea_out     out         memory write enable, always 0
//   pc          out  [15:0] current program counter
// ---------------------------------------------------------------------------
module fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic [3:0]  opCode_in,
    input  logic [8:0]  offset_in,
    input  logic [15:0] reg_in,
    input  logic [2:0]  br_nzp,
    input  logic [2:0]  result_nzp,
    output logic [15:0] addr_out,
    output logic        wea_out,
    output logic [15:0] pc
);

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpJsr  = 4'b0100;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpTrap = 4'b1111;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc_inc;
    logic [15:0] offset_sext;
    logic        br_taken;

    assign pc_inc      = pc_q + 16'd1;
    assign offset_sext = {{7{offset_in[8]}}, offset_in};
    assign br_taken    = |(br_nzp & result_nzp);

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (state_q == StRun && fetch_start) begin
            case (opCode_in)
                OpBr:    pc_d = br_taken ? (pc_inc + offset_sext) : pc_inc;
                OpJmp:   pc_d = reg_in;
                OpJsr:   pc_d = reg_in;
                // TRAP is treated as HALT: PC stays on the halting instruction
                OpTrap:  state_d = StHalt;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= StRun;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc       = pc_q;
    assign addr_out = pc_q;
    assign wea_out  = 1'b0;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vectors, a behavioural next-PC model checked on
// every falling edge, and literal expectations at key points.
module tb_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic [3:0]  opCode_in;
    logic [8:0]  offset_in;
    logic [15:0] reg_in;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic [15:0] addr_out;
    logic        wea_out;
    logic [15:0] pc;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int  m_pc     = 0;
    bit  m_halted = 0;
    bit  m_valid  = 0;

    fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_start(fetch_start),
        .opCode_in  (opCode_in),
        .offset_in  (offset_in),
        .reg_in     (reg_in),
        .br_nzp     (br_nzp),
        .result_nzp (result_nzp),
        .addr_out   (addr_out),
        .wea_out    (wea_out),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: next PC from the architectural rules, in integers.
    always @(posedge clk) begin
        int off;
        off = (offset_in[8]) ? int'(offset_in) - 512 : int'(offset_in);
        if (rst_n) begin
            m_pc     = 0;
            m_halted = 0;
            m_valid  = 1;
        end else if (fetch_start && !m_halted) begin
            if (opCode_in == 4'd0) begin
                if ((br_nzp & result_nzp) != 3'b000) m_pc = (m_pc + 1 + off) % 65536;
                else m_pc = (m_pc + 1) % 65536;
                if (m_pc < 0) m_pc = m_pc + 65536;
            end else if (opCode_in == 4'd12 || opCode_in == 4'd4) begin
                m_pc = int'(reg_in);
            end else if (opCode_in == 4'd15) begin
                m_halted = 1;
            end else begin
                m_pc = (m_pc + 1) % 65536;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (pc !== m_pc[15:0] || addr_out !== m_pc[15:0] || wea_out !== 1'b0) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t: pc=%h addr_out=%h wea_out=%b, required pc=addr_out=%h wea_out=0",
                         $time, pc, addr_out, wea_out, m_pc[15:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input logic fs, input logic [3:0] op, input logic [8:0] off = 9'h0,
                        input logic [15:0] rv = 16'h0, input logic [2:0] bn = 3'b000,
                        input logic [2:0] rn = 3'b000, input logic rst = 1'b0);
        fetch_start = fs;
        opCode_in   = op;
        offset_in   = off;
        reg_in      = rv;
        br_nzp      = bn;
        result_nzp  = rn;
        rst_n       = rst;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        rst_n       = 1'b0;
    endtask

    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] BR  = 4'b0000;
    localparam logic [3:0] JMP = 4'b1100;
    localparam logic [3:0] JSR = 4'b0100;
    localparam logic [3:0] HLT = 4'b1111;

    initial begin
        fetch_start = 0; opCode_in = HLT; offset_in = 0; reg_in = 0;
        br_nzp = 0; result_nzp = 0; rst_n = 1;
        for (int i = 0; i < 5; i++) step(1'b0, HLT, 9'h0, 16'h0, 3'b000, 3'b000, 1'b1);
        chk("reset_pc", pc, 16'h0000);
        chk("reset_addr", addr_out, 16'h0000);
        chk("reset_wea", {15'h0, wea_out}, 16'h0000);
        step(1'b0, HLT);
        step(1'b0, HLT);
        chk("idle_hold", pc, 16'h0000);

        for (int i = 1; i <= 3; i++) begin
            step(1'b1, ADD);
            chk("add_seq", pc, 16'(i));
            chk("add_addr", addr_out, 16'(i));
        end

        step(1'b1, JMP, 9'h0, 16'h0010);
        step(1'b1, BR, 9'h005, 16'h0, 3'b010, 3'b010);
        chk("br_taken", pc, 16'h0016);
        step(1'b1, JMP, 9'h0, 16'h0010);
        step(1'b1, BR, 9'h005, 16'h0, 3'b010, 3'b001);
        chk("br_not_taken", pc, 16'h0011);
        step(1'b1, JMP, 9'h0, 16'h0010);
        step(1'b1, BR, 9'h1FE, 16'h0, 3'b111, 3'b100);
        chk("br_neg_off", pc, 16'h000F);
        step(1'b1, BR, 9'h0F0, 16'h0, 3'b000, 3'b111);
        chk("br_nzp_000", pc, 16'h0010);

        step(1'b1, JMP, 9'h0, 16'h3000);
        chk("jmp", pc, 16'h3000);
        step(1'b1, JSR, 9'h0, 16'h1234);
        chk("jsr", pc, 16'h1234);
        step(1'b1, 4'b1000);
        chk("rti_seq", pc, 16'h1235);
        step(1'b1, 4'b1101);
        chk("rsvd_seq", pc, 16'h1236);
        step(1'b0, JMP, 9'h0, 16'hBEEF);
        chk("no_strobe_hold", pc, 16'h1236);

        step(1'b1, JMP, 9'h0, 16'h0004);
        step(1'b1, ADD);
        chk("pre_halt", pc, 16'h0005);
        step(1'b1, HLT);
        chk("halt_hold", pc, 16'h0005);
        step(1'b1, ADD);
        step(1'b1, JMP, 9'h0, 16'h7777);
        chk("halted_ignore", pc, 16'h0005);
        step(1'b0, ADD, 9'h0, 16'h0, 3'b000, 3'b000, 1'b1);
        chk("halt_reset", pc, 16'h0000);
        step(1'b1, ADD);
        chk("resume_add", pc, 16'h0001);

        step(1'b1, JMP, 9'h0, 16'hFFFF);
        step(1'b1, ADD);
        chk("wrap_inc", pc, 16'h0000);
        step(1'b1, BR, 9'h1FF, 16'h0, 3'b001, 3'b001);
        chk("br_m1_at0", pc, 16'h0000);
        step(1'b1, BR, 9'h1FE, 16'h0, 3'b100, 3'b100);
        chk("br_wrap_below0", pc, 16'hFFFF);
        step(1'b1, JMP, 9'h0, 16'h0042);
        step(1'b1, ADD, 9'h0, 16'h0, 3'b000, 3'b000, 1'b1);
        chk("reset_beats_strobe", pc, 16'h0000);
        step(1'b0, ADD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
